// File: rtl/uart_tx_sched.sv
// Byte FIFO feeding an 8N1 UART transmitter with runtime baud divisor.
// Stalls the pipeline through uart_stop while the FIFO is full.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD       = 115200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   clk_rate,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          uart_stop,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [7:0]  r_shift, w_shift;
  logic [2:0]  r_bit, w_bit;
  logic [31:0] r_tick, w_tick;
  logic [31:0] r_bt, w_bt;
  logic [31:0] w_quot, w_rate_bt;
  logic        r_out, w_out;
  logic        w_full, w_empty;
  logic        w_push, w_pop;
  logic        w_tick_done;

  assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_push      = wr_en & ~w_full;
  assign w_quot      = clk_rate / 32'(BAUD);
  assign w_rate_bt   = (w_quot == '0) ? 32'd1 : w_quot;
  assign w_tick_done = (r_tick == '0);

  assign uart_stop  = wr_en & w_full;
  assign tx_busy    = (r_state != S_IDLE) | ~w_empty;
  assign fifo_count = r_cnt;
  assign uart_out   = r_out;

  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_bit   = r_bit;
    w_tick  = r_tick;
    w_bt    = r_bt;
    w_out   = r_out;
    w_pop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_out = 1'b1;
        w_pop = ~w_empty;
      end
      S_START: begin
        if (w_tick_done) begin
          w_state = S_DATA;
          w_bit   = 3'd0;
          w_tick  = r_bt - 32'd1;
          w_out   = r_shift[0];
        end else begin
          w_tick = r_tick - 32'd1;
        end
      end
      S_DATA: begin
        if (w_tick_done) begin
          w_tick = r_bt - 32'd1;
          if (r_bit == 3'd7) begin
            w_state = S_STOP;
            w_out   = 1'b1;
          end else begin
            w_shift = r_shift >> 1;
            w_bit   = r_bit + 3'd1;
            w_out   = r_shift[1];
          end
        end else begin
          w_tick = r_tick - 32'd1;
        end
      end
      S_STOP: begin
        if (w_tick_done) begin
          w_state = S_IDLE;
          w_out   = 1'b1;
          w_pop   = ~w_empty;
        end else begin
          w_tick = r_tick - 32'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // Any pop starts a fresh frame with the divisor sampled now.
    if (w_pop) begin
      w_state = S_START;
      w_shift = r_mem[r_rp];
      w_bt    = w_rate_bt;
      w_tick  = w_rate_bt - 32'd1;
      w_out   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tick  <= '0;
      r_bt    <= 32'd1;
      r_out   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_tick  <= w_tick;
      r_bt    <= w_bt;
      r_out   <= w_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= wr_data;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized and directed bench for uart_tx_sched.
// A frame-schedule model predicts the line, count, busy and stall each cycle.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int BAUD  = 1_000_000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] clk_rate = 32'd16_000_000;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        uart_stop;
  logic        tx_busy;
  logic [2:0]  fifo_count;
  logic        uart_out;

  uart_tx_sched #(
    .FIFO_DEPTH(DEPTH),
    .BAUD(BAUD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_rate(clk_rate),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .uart_stop(uart_stop),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count),
    .uart_out(uart_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  function automatic int bt_of(input logic [31:0] r);
    int q;
    q = int'(r / 32'(BAUD));
    return (q == 0) ? 1 : q;
  endfunction

  // Model: queue of pending bytes plus the time window of the frame on the line.
  logic [7:0] mq[$];
  longint     t = 0;
  longint     fs = 0;
  longint     fe = 0;
  int         fbt = 1;
  int         k;
  logic [7:0] fb = 8'h00;
  logic       acc;
  logic       m_out = 1'b1;
  int         m_cnt = 0;
  logic       m_busy = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      fe = t;
      m_out = 1'b1;
      m_cnt = 0;
      m_busy = 1'b0;
    end else begin
      t++;
      acc = wr_en && (mq.size() < DEPTH);
      if (mq.size() > 0 && t >= fe) begin
        fb  = mq.pop_front();
        fs  = t;
        fbt = bt_of(clk_rate);
        fe  = t + 10 * fbt;
      end
      if (acc) mq.push_back(wr_data);
      m_cnt  = mq.size();
      m_busy = (t < fe) || (mq.size() > 0);
      if (t < fe) begin
        k = int'((t - fs) / fbt);
        if (k == 0) m_out = 1'b0;
        else if (k <= 8) m_out = fb[k-1];
        else m_out = 1'b1;
      end else begin
        m_out = 1'b1;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("uart_out", uart_out, m_out);
      chk("fifo_count", fifo_count, m_cnt);
      chk("tx_busy", tx_busy, m_busy);
      chk("uart_stop", uart_stop, wr_en && (m_cnt == DEPTH));
    end
  end

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    wr_en = 1'b1;
    wr_data = b;
    #1;
    while (uart_stop && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("push_ready", uart_stop, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (tx_busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", tx_busy, 1'b0);
  endtask

  task automatic busy_len(input int start, output int n);
    n = start;
    while (tx_busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int len;
  int lows;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_line", uart_out, 1'b1);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_stop", uart_stop, 1'b0);
    chk_en = 1'b1;
    reset = 1'b0;
    @(negedge clk);

    // single byte
    push(8'hA5);
    @(negedge clk);
    busy_len(0, len);
    chk("t1_frame_len", len, 160);
    repeat (5) @(negedge clk);

    // two back-to-back bytes
    push(8'h01);
    push(8'h80);
    busy_len(0, len);
    chk("t2_two_frames", len, 320);
    repeat (5) @(negedge clk);

    // overflow and stall
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    wr_en = 1'b1;
    wr_data = 8'h66;
    #1;
    chk("t3_count_full", fifo_count, 3'd4);
    chk("t3_stall", uart_stop, 1'b1);
    push(8'h66);
    wait_idle(3000);
    repeat (5) @(negedge clk);

    // reset mid-frame
    push(8'h00);
    push(8'hC3);
    push(8'h3C);
    repeat (38) @(negedge clk);
    chk("t4_pre_line", uart_out, 1'b0);
    chk("t4_pre_count", fifo_count, 3'd2);
    #3;
    reset = 1'b1;
    #1;
    chk("t4_rst_line", uart_out, 1'b1);
    chk("t4_rst_count", fifo_count, 3'd0);
    chk("t4_rst_busy", tx_busy, 1'b0);
    @(negedge clk);
    #3;
    reset = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (!uart_out) lows++;
    end
    chk("t4_no_frame", lows, 0);

    // divisor clamp and mid-frame rate change
    clk_rate = 32'd500_000;
    push(8'h5A);
    repeat (3) @(negedge clk);
    clk_rate = 32'd32_000_000;
    push(8'h96);
    busy_len(3, len);
    chk("t5_frames_len", len, 330);
    repeat (5) @(negedge clk);

    // randomized traffic with changing rates
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) clk_rate = 32'd300_000;
        else clk_rate = 32'($urandom_range(1, 6)) * 32'd1_000_000;
      end
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(0, 25)) @(negedge clk);
      end
      push(8'($urandom));
    end
    wait_idle(20000);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
